// File: rtl/lift_pkg.sv
// Shared types for the lift call scheduler.
//   state_t     : motion/door sequencer states
//   dir_t       : SCAN sweep direction, kept across idle periods
//   floor_width : bit width of a floor index for an N-floor shaft
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  function automatic int floor_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lift_door_timer.sv
// Door dwell down-counter.
//   clk, rst : clock, synchronous active-high reset (counter -> 0)
//   load     : door being entered, start a fresh dwell
//   reload   : call at the open door, restart the dwell
//   done     : counter has reached terminal count 0
module lift_door_timer #(
  parameter int DOOR_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic reload,
  output logic done
);

  localparam int CW = $clog2(DOOR_CYCLES);
  // Loading DOOR_CYCLES-1 and counting down to 0 gives exactly DOOR_CYCLES
  // cycles in the door state, since the exit happens on the cycle at 0.
  localparam logic [CW-1:0] DWELL_LAST = CW'(DOOR_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || reload) begin
      cnt <= DWELL_LAST;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lift_call_scheduler.sv
// Lift call scheduler: latches cab/hall calls, tracks the car floor from
// arrival pulses and serves calls in SCAN order.
//   clk, rst                  : clock, synchronous active-high reset
//   cab_req                   : cab buttons, one per floor
//   hall_up_req / hall_dn_req : hall calls (top up / bottom down ignored)
//   floor_arrive              : car reached next floor in commanded direction
//   cur_floor                 : current floor index
//   move_up, move_dn          : motor commands (Moore, mutually exclusive)
//   door_open                 : door command
//   pend_cab/pend_up/pend_dn  : latched pending calls
//   busy                      : moving, door open, or any call pending
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | parked with door shut, choosing the next action
// ST_UP   | motor driving up, waiting for the next arrival pulse
// ST_DN   | motor driving down, waiting for the next arrival pulse
// ST_DOOR | door open, dwell timer running
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter  int N           = 3,
  parameter  int DOOR_CYCLES = 5_000_000,
  localparam int FW          = floor_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  cab_req,
  input  logic [N-1:0]  hall_up_req,
  input  logic [N-1:0]  hall_dn_req,
  input  logic          floor_arrive,
  output logic [FW-1:0] cur_floor,
  output logic          move_up,
  output logic          move_dn,
  output logic          door_open,
  output logic [N-1:0]  pend_cab,
  output logic [N-1:0]  pend_up,
  output logic [N-1:0]  pend_dn,
  output logic          busy
);

  localparam logic [N-1:0] UP_VALID = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] DN_VALID = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  state_t        state, state_n;
  dir_t          dir, dir_n;
  logic [FW-1:0] floor_n, floor_up, floor_dn;
  logic [N-1:0]  pend_any, above, below;
  logic [N-1:0]  here, here_up, here_dn;
  logic [N-1:0]  clr_cab, clr_up, clr_dn;
  logic [N-1:0]  blk_cab, blk_up, blk_dn;
  logic          door_load, door_reload, door_done;

  assign pend_any = pend_cab | pend_up | pend_dn;

  // above[i] / below[i]: any call strictly above / below floor i.
  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j > i) above[i] = above[i] | pend_any[j];
        if (j < i) below[i] = below[i] | pend_any[j];
      end
    end
  end

  // Next floor in each direction; held at the ends so the index never wraps.
  assign floor_up = (cur_floor == FW'(N - 1)) ? cur_floor : cur_floor + 1'b1;
  assign floor_dn = (cur_floor == '0) ? cur_floor : cur_floor - 1'b1;
  assign here     = ONE << cur_floor;
  assign here_up  = ONE << floor_up;
  assign here_dn  = ONE << floor_dn;

  always_comb begin
    state_n     = state;
    dir_n       = dir;
    floor_n     = cur_floor;
    clr_cab     = '0;
    clr_up      = '0;
    clr_dn      = '0;
    blk_cab     = '0;
    blk_up      = '0;
    blk_dn      = '0;
    door_load   = 1'b0;
    door_reload = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_any[cur_floor]) begin
          state_n   = ST_DOOR;
          door_load = 1'b1;
          clr_cab   = here;
          clr_up    = here;
          clr_dn    = here;
        end else if (above[cur_floor] && below[cur_floor]) begin
          state_n = (dir == DIR_UP) ? ST_UP : ST_DN;
        end else if (above[cur_floor]) begin
          state_n = ST_UP;
          dir_n   = DIR_UP;
        end else if (below[cur_floor]) begin
          state_n = ST_DN;
          dir_n   = DIR_DN;
        end
      end
      ST_UP: begin
        if (floor_arrive) begin
          floor_n = floor_up;
          if (pend_cab[floor_up] || pend_up[floor_up] || !above[floor_up] ||
              floor_up == FW'(N - 1)) begin
            state_n   = ST_DOOR;
            door_load = 1'b1;
            clr_cab   = here_up;
            clr_up    = here_up;
            // End of the sweep: the down call here is served by this stop too.
            if (!above[floor_up]) begin
              clr_dn = here_up;
              dir_n  = DIR_DN;
            end
          end
        end
      end
      ST_DN: begin
        if (floor_arrive) begin
          floor_n = floor_dn;
          if (pend_cab[floor_dn] || pend_dn[floor_dn] || !below[floor_dn] ||
              floor_dn == '0) begin
            state_n   = ST_DOOR;
            door_load = 1'b1;
            clr_cab   = here_dn;
            clr_dn    = here_dn;
            if (!below[floor_dn]) begin
              clr_up = here_dn;
              dir_n  = DIR_UP;
            end
          end
        end
      end
      ST_DOOR: begin
        // Calls the open door already serves extend the dwell instead of latching.
        blk_cab = here;
        if (dir == DIR_UP) blk_up = here;
        else               blk_dn = here;
        door_reload = (|(cab_req & blk_cab)) ||
                      (|(hall_up_req & UP_VALID & blk_up)) ||
                      (|(hall_dn_req & DN_VALID & blk_dn));
        if (!door_reload && door_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir       <= DIR_UP;
      cur_floor <= '0;
      pend_cab  <= '0;
      pend_up   <= '0;
      pend_dn   <= '0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      cur_floor <= floor_n;
      pend_cab  <= (pend_cab | (cab_req & ~blk_cab)) & ~clr_cab;
      pend_up   <= (pend_up | (hall_up_req & UP_VALID & ~blk_up)) & ~clr_up;
      pend_dn   <= (pend_dn | (hall_dn_req & DN_VALID & ~blk_dn)) & ~clr_dn;
    end
  end

  lift_door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (door_load),
    .reload (door_reload),
    .done   (door_done)
  );

  assign move_up   = (state == ST_UP);
  assign move_dn   = (state == ST_DN);
  assign door_open = (state == ST_DOOR);
  assign busy      = (state != ST_IDLE) || (|pend_any);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Self-checking bench for lift_call_scheduler (N=3, DOOR_CYCLES=4):
// a constant-expectation vector table, hand sequences for SCAN reversal,
// door reload and direction memory, then random traffic against a model.
module tb_lift_call_scheduler;

  localparam int N    = 3;
  localparam int DOOR = 4;

  logic       clk;
  logic       rst;
  logic [2:0] cab_req, hall_up_req, hall_dn_req;
  logic       floor_arrive;
  logic [1:0] cur_floor;
  logic       move_up, move_dn, door_open, busy;
  logic [2:0] pend_cab, pend_up, pend_dn;

  int checks = 0;
  int errors = 0;

  lift_call_scheduler #(.N(N), .DOOR_CYCLES(DOOR)) dut (
    .clk          (clk),
    .rst          (rst),
    .cab_req      (cab_req),
    .hall_up_req  (hall_up_req),
    .hall_dn_req  (hall_dn_req),
    .floor_arrive (floor_arrive),
    .cur_floor    (cur_floor),
    .move_up      (move_up),
    .move_dn      (move_dn),
    .door_open    (door_open),
    .pend_cab     (pend_cab),
    .pend_up      (pend_up),
    .pend_dn      (pend_dn),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // m_mot: +1 driving up, -1 driving down, 0 not moving.
  // m_door: door cycles still to show, counting the current one (0 = shut).
  int m_floor, m_mot, m_door, m_dir;
  bit m_cab[N], m_up[N], m_dn[N];

  function automatic bit m_any(int f);
    return m_cab[f] || m_up[f] || m_dn[f];
  endfunction

  function automatic bit m_ahead(int f, int d);
    for (int j = f + d; j >= 0 && j < N; j += d)
      if (m_any(j)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_mot = 0; m_door = 0; m_dir = 1;
    for (int i = 0; i < N; i++) begin
      m_cab[i] = 0; m_up[i] = 0; m_dn[i] = 0;
    end
  endtask

  task automatic model_step();
    bit s_cab[N], s_up[N], s_dn[N], c_cab[N], c_up[N], c_dn[N];
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      s_cab[i] = cab_req[i];
      s_up[i]  = hall_up_req[i] && (i != N - 1);
      s_dn[i]  = hall_dn_req[i] && (i != 0);
      c_cab[i] = 0; c_up[i] = 0; c_dn[i] = 0;
    end
    if (m_door > 0) begin
      bit again;
      again = s_cab[m_floor] || (m_dir > 0 ? s_up[m_floor] : s_dn[m_floor]);
      s_cab[m_floor] = 0;
      if (m_dir > 0) s_up[m_floor] = 0;
      else           s_dn[m_floor] = 0;
      m_door = again ? DOOR : m_door - 1;
    end else if (m_mot != 0) begin
      if (floor_arrive) begin
        int f;
        bit ahead, call_here, end_floor;
        f         = m_floor + m_mot;
        ahead     = m_ahead(f, m_mot);
        call_here = m_cab[f] || (m_mot > 0 ? m_up[f] : m_dn[f]);
        end_floor = (m_mot > 0) ? (f == N - 1) : (f == 0);
        m_floor   = f;
        if (call_here || !ahead || end_floor) begin
          c_cab[f] = 1;
          if (m_mot > 0) c_up[f] = 1; else c_dn[f] = 1;
          if (!ahead) begin
            if (m_mot > 0) c_dn[f] = 1; else c_up[f] = 1;
            m_dir = -m_mot;
          end
          m_mot  = 0;
          m_door = DOOR;
        end
      end
    end else begin
      bit ab, be;
      ab = m_ahead(m_floor, 1);
      be = m_ahead(m_floor, -1);
      if (m_any(m_floor)) begin
        c_cab[m_floor] = 1; c_up[m_floor] = 1; c_dn[m_floor] = 1;
        m_door = DOOR;
      end else if (ab && be) begin
        m_mot = m_dir;
      end else if (ab) begin
        m_mot = 1; m_dir = 1;
      end else if (be) begin
        m_mot = -1; m_dir = -1;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_cab[i] = (m_cab[i] || s_cab[i]) && !c_cab[i];
      m_up[i]  = (m_up[i]  || s_up[i])  && !c_up[i];
      m_dn[i]  = (m_dn[i]  || s_dn[i])  && !c_dn[i];
    end
  endtask

  function automatic logic [14:0] model_vec();
    logic [2:0] pc, pu, pd;
    for (int i = 0; i < N; i++) begin
      pc[i] = m_cab[i]; pu[i] = m_up[i]; pd[i] = m_dn[i];
    end
    return {2'(m_floor), m_mot > 0, m_mot < 0, m_door > 0, pc, pu, pd,
            (m_mot != 0) || (m_door > 0) || (|{pc, pu, pd})};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {cur_floor, move_up, move_dn, door_open, pend_cab, pend_up, pend_dn, busy};
  endfunction

  // ---------------- checking / driving helpers ----------------
  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, clock, then compare the DUT with the model.
  task automatic cyc(input logic r, input logic [2:0] cb, input logic [2:0] hu,
                     input logic [2:0] hd, input logic a);
    rst = r; cab_req = cb; hall_up_req = hu; hall_dn_req = hd; floor_arrive = a;
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_vec(), model_vec());
    rst = 0; cab_req = '0; hall_up_req = '0; hall_dn_req = '0; floor_arrive = 0;
  endtask

  task automatic nop();
    cyc(0, 3'b000, 3'b000, 3'b000, 0);
  endtask

  task automatic arrive();
    cyc(0, 3'b000, 3'b000, 3'b000, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r;
    logic [2:0] cab, hu, hd;
    logic       arr;
    logic [1:0] floor;
    logic       mu, md, door;
    logic [2:0] pc, pu, pd;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [2:0] cab, logic [2:0] hu, logic [2:0] hd,
                              logic arr, logic [1:0] fl, logic mu, logic md, logic door,
                              logic [2:0] pc, logic [2:0] pu, logic [2:0] pd, logic b);
    vec_t v;
    v.r = r; v.cab = cab; v.hu = hu; v.hd = hd; v.arr = arr;
    v.floor = fl; v.mu = mu; v.md = md; v.door = door;
    v.pc = pc; v.pu = pu; v.pd = pd; v.busy = b;
    return v;
  endfunction

  initial begin
    int n;
    rst = 1; cab_req = '0; hall_up_req = '0; hall_dn_req = '0; floor_arrive = 0;
    model_reset();

    //                  r  cab     hu      hd      a   fl   mu md dr  pc      pu      pd      busy
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0, 3'b100, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 1, 0, 0, 3'b100, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 2'd1, 1, 0, 0, 3'b100, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd1, 1, 0, 0, 3'b100, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 2'd2, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 3'b100, 3'b001, 0, 2'd2, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, 2'd2, 0, 0, 0, 3'b100, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 1, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 0, 2'd2, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd2, 0, 1, 0, 3'b001, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 2'd1, 0, 1, 0, 3'b001, 3'b000, 3'b000, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'd0, 1, 0, 0, 3'b010, 3'b000, 3'b000, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].cab, tbl[i].hu, tbl[i].hd, tbl[i].arr);
      chk($sformatf("tbl[%0d]", i), dut_vec(),
          {tbl[i].floor, tbl[i].mu, tbl[i].md, tbl[i].door,
           tbl[i].pc, tbl[i].pu, tbl[i].pd, tbl[i].busy});
    end

    // SCAN: pass floor 1 going up, stop at 2, reverse to serve down call at 1.
    cyc(0, 3'b100, 3'b000, 3'b010, 0);
    nop();
    chk("scan_up_start", 15'(move_up), 15'd1);
    arrive();
    chk("pass_floor1", 15'({door_open, move_up, cur_floor}), 15'({1'b0, 1'b1, 2'd1}));
    arrive();
    chk("stop_floor2", 15'({door_open, cur_floor}), 15'({1'b1, 2'd2}));
    nop(); nop(); nop(); nop();
    chk("idle_after_door", 15'({door_open, move_dn}), 15'd0);
    nop();
    chk("reverse_dn", 15'(move_dn), 15'd1);
    arrive();
    chk("serve_dn1", 15'({door_open, cur_floor, pend_dn}), 15'({1'b1, 2'd1, 3'b000}));
    for (int k = 0; k < 5; k++) nop();

    // Door reload: cab call at the open door floor with counter at 1.
    cyc(1, 3'b000, 3'b000, 3'b000, 0);
    cyc(0, 3'b100, 3'b000, 3'b000, 0);
    nop();
    arrive();
    arrive();
    nop();
    nop();
    cyc(0, 3'b100, 3'b000, 3'b000, 0);
    chk("reload_no_latch", 15'({door_open, pend_cab}), 15'({1'b1, 3'b000}));
    n = 0;
    for (int k = 0; k < 20 && door_open; k++) begin
      n++;
      nop();
    end
    chk("reload_dwell", 15'(n), 15'd4);

    // Direction memory: idle at floor 1 heading down with calls at 0 and 2.
    cyc(0, 3'b011, 3'b000, 3'b000, 0);
    nop();
    arrive();
    chk("stop_cab1", 15'({door_open, cur_floor}), 15'({1'b1, 2'd1}));
    cyc(0, 3'b100, 3'b000, 3'b000, 0);
    chk("latch_cab2", 15'(pend_cab), 15'(3'b101));
    nop(); nop(); nop();
    chk("idle_floor1", 15'({door_open, move_up, move_dn}), 15'd0);
    nop();
    chk("keeps_dn", 15'({move_up, move_dn}), 15'(2'b01));
    arrive();
    chk("stop_floor0", 15'({door_open, cur_floor}), 15'({1'b1, 2'd0}));
    nop(); nop(); nop(); nop();
    nop();
    chk("turn_up", 15'({move_up, move_dn}), 15'(2'b10));
    arrive();
    arrive();
    chk("serve_cab2", 15'({door_open, cur_floor, pend_cab}), 15'({1'b1, 2'd2, 3'b000}));

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic       r, a;
      logic [2:0] cb, hu, hd;
      r = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N; b++) begin
        cb[b] = ($urandom_range(0, 11) == 0);
        hu[b] = ($urandom_range(0, 11) == 0);
        hd[b] = ($urandom_range(0, 11) == 0);
      end
      a = (m_mot != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cyc(r, cb, hu, hd, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
